// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM state
// encodings, branch-compare codes, PC width/step and the branch offset helper.
package pc_seq_pkg;

   localparam int PC_W = 16;
   localparam logic [PC_W-1:0] PC_STEP = 16'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FETCH  = 2'b01,
      EXEC   = 2'b10,
      HALTED = 2'b11
   } seqState_t;

   typedef enum logic [1:0] {
      BR_EQ  = 2'b00,
      BR_LT  = 2'b01,
      BR_NEQ = 2'b10,
      BR_GEQ = 2'b11
   } brControl_t;

   // imm is a signed word offset; instructions are 2 bytes wide.
   function automatic logic [PC_W-1:0] branchOffset(input logic [6:0] imm);
      return {{(PC_W - 8){imm[6]}}, imm, 1'b0};
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch evaluator: unsigned compare of the decode operands and
// the pc-relative branch target.
module branch_cond_eval
   import pc_seq_pkg::*;
(
   input  logic [1:0]      br_control,
   input  logic [PC_W-1:0] in0,
   input  logic [PC_W-1:0] in1,
   input  logic [6:0]      imm,
   input  logic [PC_W-1:0] pc,
   output logic            taken,
   output logic [PC_W-1:0] target
);

   always_comb begin
      taken = 1'b0;
      case (brControl_t'(br_control))
         BR_EQ:  taken = (in0 == in1);
         BR_LT:  taken = (in0 <  in1);
         BR_NEQ: taken = (in0 != in1);
         BR_GEQ: taken = (in0 >= in1);
         default: taken = 1'b0;
      endcase
   end

   assign target = pc + branchOffset(imm);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute sequencer with branch resolution.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             halt,
   output logic             imem_req,
   output logic [15:0]      imem_addr,
   input  logic             imem_ack,
   output logic             instr_valid,
   input  logic             br_valid,
   input  logic [1:0]       br_control,
   input  logic [15:0]      br_in0,
   input  logic [15:0]      br_in1,
   input  logic [6:0]       br_imm,
   output logic [15:0]      pc,
   output logic [1:0]       seq_state,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   seqState_t       stateReg, stateNext;
   logic [PC_W-1:0] pcReg, pcNext;
   logic [PC_W-1:0] brTarget;
   logic            condTrue;
   logic            brTaken;

   branch_cond_eval uCond (
      .br_control (br_control),
      .in0        (br_in0),
      .in1        (br_in1),
      .imm        (br_imm),
      .pc         (pcReg),
      .taken      (condTrue),
      .target     (brTarget)
   );

   assign brTaken = br_valid && condTrue;

   always_comb begin
      stateNext   = stateReg;
      pcNext      = pcReg;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (stateReg)
         IDLE: begin
            if (run) stateNext = FETCH;
         end
         FETCH: begin
            // An issued fetch always completes; run/halt wait for the ack.
            imem_req = 1'b1;
            if (imem_ack) stateNext = EXEC;
         end
         EXEC: begin
            instr_valid = 1'b1;
            pcNext      = brTaken ? brTarget : pcReg + PC_STEP;
            if (halt)      stateNext = HALTED;
            else if (!run) stateNext = IDLE;
            else           stateNext = FETCH;
         end
         HALTED: begin
            stateNext = HALTED;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= IDLE;
         pcReg    <= RESET_PC;
      end else begin
         stateReg <= stateNext;
         pcReg    <= pcNext;
      end
   end

   assign pc        = pcReg;
   assign imem_addr = pcReg;
   assign seq_state = stateReg;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] branchCntReg, takenCntReg;
   logic             brResolved;

   assign brResolved = (stateReg == EXEC) && br_valid;

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         branchCntReg <= '0;
         takenCntReg  <= '0;
      end else if (brResolved) begin
         if (branchCntReg != '1) branchCntReg <= branchCntReg + CNT_W'(1);
         if (condTrue && (takenCntReg != '1)) takenCntReg <= takenCntReg + CNT_W'(1);
      end
   end

   assign branch_cnt = branchCntReg;
   assign taken_cnt  = takenCntReg;
`else
   assign branch_cnt = '0;
   assign taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed branch cases plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        halt = 1'b0;
   logic        imem_ack = 1'b0;
   logic        br_valid = 1'b0;
   logic [1:0]  br_control = 2'b00;
   logic [15:0] br_in0 = 16'h0000;
   logic [15:0] br_in1 = 16'h0000;
   logic [6:0]  br_imm = 7'h00;

   logic        imem_req, instr_valid;
   logic [15:0] imem_addr, pc;
   logic [1:0]  seq_state;
   logic [15:0] branch_cnt, taken_cnt;

   logic        d2Req, d2Valid;
   logic [15:0] d2Addr, d2Pc;
   logic [1:0]  d2State;
   logic [1:0]  branchCnt2, takenCnt2;

   pc_sequencer #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .run(run), .halt(halt),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .instr_valid(instr_valid), .br_valid(br_valid), .br_control(br_control),
      .br_in0(br_in0), .br_in1(br_in1), .br_imm(br_imm), .pc(pc),
      .seq_state(seq_state), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   // Narrow-counter copy driven identically, used to observe saturation.
   pc_sequencer #(.RESET_PC(16'h0000), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .run(run), .halt(halt),
      .imem_req(d2Req), .imem_addr(d2Addr), .imem_ack(imem_ack),
      .instr_valid(d2Valid), .br_valid(br_valid), .br_control(br_control),
      .br_in0(br_in0), .br_in1(br_in1), .br_imm(br_imm), .pc(d2Pc),
      .seq_state(d2State), .branch_cnt(branchCnt2), .taken_cnt(takenCnt2)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] expPc;
   int          expBr, expTk;

   localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_HALTED = 2'd3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: next pc of one executed instruction, from plain integer arithmetic.
   function automatic logic [15:0] refNext(input logic [15:0] p, input logic v,
                                           input logic [1:0] c, input logic [15:0] a,
                                           input logic [15:0] b, input logic [6:0] imm,
                                           output logic tk);
      int off;
      int ia, ib;
      bit cond;
      ia  = int'(a);
      ib  = int'(b);
      off = (int'(imm) >= 64) ? int'(imm) - 128 : int'(imm);
      case (c)
         2'd0: cond = (ia == ib);
         2'd1: cond = (ia <  ib);
         2'd2: cond = (ia != ib);
         default: cond = (ia >= ib);
      endcase
      tk = v && cond;
      return tk ? 16'((int'(p) + 2 * off) % 65536 + 65536) : 16'(int'(p) + 2);
   endfunction

   function automatic logic [31:0] satExp(input int n, input int w);
`ifdef BRANCH_STATS_EN
      int top;
      top = (1 << w) - 1;
      return 32'((n > top) ? top : n);
`else
      return 32'(0 * n * w);
`endif
   endfunction

   task automatic chkCounters(input string tag);
      chk({tag, "_branch_cnt"}, 32'(branch_cnt), satExp(expBr, 16));
      chk({tag, "_taken_cnt"},  32'(taken_cnt),  satExp(expTk, 16));
      chk({tag, "_branch_cnt_w2"}, 32'(branchCnt2), satExp(expBr, 2));
      chk({tag, "_taken_cnt_w2"},  32'(takenCnt2),  satExp(expTk, 2));
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      expPc = 16'h0000;
      expBr = 0;
      expTk = 0;
      chk("rst_state", 32'(seq_state), 32'(S_IDLE));
      chk("rst_pc", 32'(pc), 32'h0000);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chkCounters("rst");
      reset = 1'b0;
   endtask

   // Runs one instruction starting in FETCH; leaves the DUT one cycle after EXEC.
   task automatic doInstr(input int ackDelay, input logic bv, input logic [1:0] ctrl,
                          input logic [15:0] a, input logic [15:0] b, input logic [6:0] imm,
                          input logic runNext, input logic haltNext);
      logic tk;
      logic [15:0] nextPc;
      chk("fetch_state", 32'(seq_state), 32'(S_FETCH));
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(expPc));
      chk("fetch_valid", 32'(instr_valid), 32'd0);
      for (int d = 0; d < ackDelay; d++) begin
         run      = 1'b0;
         halt     = 1'($urandom);
         br_valid = 1'($urandom);
         tick();
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", 32'(imem_addr), 32'(expPc));
      end
      br_valid = 1'b0;
      halt     = 1'b0;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("exec_state", 32'(seq_state), 32'(S_EXEC));
      chk("exec_valid", 32'(instr_valid), 32'd1);
      chk("exec_req", 32'(imem_req), 32'd0);
      br_valid   = bv;
      br_control = ctrl;
      br_in0     = a;
      br_in1     = b;
      br_imm     = imm;
      run        = runNext;
      halt       = haltNext;
      tick();
      br_valid = 1'b0;
      halt     = 1'b0;
      nextPc = refNext(expPc, bv, ctrl, a, b, imm, tk);
      $display("instr pc=%04h bv=%0d ctrl=%0d a=%04h b=%04h imm=%02h taken=%0d -> pc=%04h",
               expPc, bv, ctrl, a, b, imm, tk, nextPc);
      expPc = nextPc;
      if (bv) expBr++;
      if (tk) expTk++;
      chk("post_pc", 32'(pc), 32'(expPc));
      chk("post_state", 32'(seq_state),
          32'(haltNext ? S_HALTED : (!runNext ? S_IDLE : S_FETCH)));
      chkCounters("post");
   endtask

   task automatic plain();
      doInstr(0, 1'b0, 2'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [6:0]  rimm;
      logic [1:0]  rc;
      logic        rv, rrun;
      int          idleN;

      // Reset, then linear fetch with immediate acks
      doReset();
      run = 1'b1;
      tick();
      chk("start_state", 32'(seq_state), 32'(S_FETCH));
      for (int i = 0; i < 8; i++) plain();
      chk("at_0010", 32'(pc), 32'h0010);

      // EQ taken / not taken from 0x0010
      doInstr(0, 1'b1, 2'd0, 16'h1234, 16'h1234, 7'h04, 1'b1, 1'b0);
      chk("eq_taken", 32'(pc), 32'h0018);
      doInstr(0, 1'b1, 2'd0, 16'h1111, 16'h1111, 7'h7C, 1'b1, 1'b0);
      doInstr(0, 1'b1, 2'd0, 16'h1234, 16'h1235, 7'h04, 1'b1, 1'b0);
      chk("eq_not_taken", 32'(pc), 32'h0012);

      // LT backward branch, then wrap below zero with NEQ
      for (int i = 0; i < 7; i++) plain();
      doInstr(0, 1'b1, 2'd1, 16'h0001, 16'h0002, 7'h7E, 1'b1, 1'b0);
      chk("lt_back", 32'(pc), 32'h001C);
      doInstr(0, 1'b1, 2'd0, 16'h0005, 16'h0005, 7'h72, 1'b1, 1'b0);
      doInstr(0, 1'b1, 2'd2, 16'h0001, 16'h0002, 7'h7F, 1'b1, 1'b0);
      chk("neq_wrap", 32'(pc), 32'hFFFE);

      // Unsigned compares with the sign bit set
      doInstr(0, 1'b1, 2'd3, 16'h8000, 16'h0001, 7'h02, 1'b1, 1'b0);
      chk("geq_unsigned", 32'(pc), 32'h0002);
      doInstr(0, 1'b1, 2'd1, 16'h8000, 16'h0001, 7'h02, 1'b1, 1'b0);
      chk("lt_unsigned", 32'(pc), 32'h0004);

      // Randomized instruction stream with stalls and idle gaps
      for (int i = 0; i < 60; i++) begin
         ra   = 16'($urandom);
         rb   = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom);
         rc   = 2'($urandom);
         rimm = 7'($urandom);
         rv   = ($urandom_range(0, 3) != 0);
         rrun = ($urandom_range(0, 5) != 0);
         doInstr(int'($urandom_range(0, 3)), rv, rc, ra, rb, rimm, rrun, 1'b0);
         if (!rrun) begin
            idleN = int'($urandom_range(1, 3));
            for (int k = 0; k < idleN; k++) begin
               br_valid = 1'b1;
               br_control = 2'($urandom);
               br_imm = 7'($urandom);
               tick();
               chk("idle_state", 32'(seq_state), 32'(S_IDLE));
               chk("idle_req", 32'(imem_req), 32'd0);
               chk("idle_pc", 32'(pc), 32'(expPc));
            end
            br_valid = 1'b0;
            run = 1'b1;
            tick();
            chk("restart_state", 32'(seq_state), 32'(S_FETCH));
         end
      end

      // Delayed ack with run dropped, then halt together with a taken branch
      doInstr(3, 1'b0, 2'd0, 16'h0, 16'h0, 7'h0, 1'b1, 1'b0);
      doInstr(3, 1'b1, 2'd3, 16'h8000, 16'h0001, 7'h05, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++) begin
         run = 1'b1;
         imem_ack = 1'($urandom);
         br_valid = 1'b1;
         tick();
         chk("halt_req", 32'(imem_req), 32'd0);
         chk("halt_state", 32'(seq_state), 32'(S_HALTED));
         chk("halt_pc", 32'(pc), 32'(expPc));
      end
      imem_ack = 1'b0;
      br_valid = 1'b0;

      // Reset during a fetch wins over the ack
      doReset();
      run = 1'b1;
      tick();
      chk("pre_rst_state", 32'(seq_state), 32'(S_FETCH));
      reset = 1'b1;
      imem_ack = 1'b1;
      tick();
      reset = 1'b0;
      imem_ack = 1'b0;
      chk("midfetch_state", 32'(seq_state), 32'(S_IDLE));
      chk("midfetch_pc", 32'(pc), 32'h0000);
      chk("midfetch_req", 32'(imem_req), 32'd0);
      tick();

      // Branch statistics: 3 resolved / 2 taken, then past the 2-bit limit
      doInstr(0, 1'b1, 2'd0, 16'h0007, 16'h0007, 7'h02, 1'b1, 1'b0);
      doInstr(1, 1'b1, 2'd1, 16'h0009, 16'h0003, 7'h02, 1'b1, 1'b0);
      doInstr(0, 1'b1, 2'd2, 16'h0009, 16'h0003, 7'h02, 1'b1, 1'b0);
      plain();
      doInstr(0, 1'b1, 2'd3, 16'h0004, 16'h0004, 7'h02, 1'b1, 1'b0);
      doInstr(2, 1'b1, 2'd0, 16'h0001, 16'h0002, 7'h02, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
